// File: rtl/ucomb_scan.sv
// Pin-sweep controller for the universal-gate wiring decoder: captures one gate request,
// probes each used pin in turn, and returns the packed per-pin wiring map.
module ucomb_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic [15:0] req_func,
  output logic [1:0]  ref_sel,
  output logic [15:0] ref_func,
  output logic [3:0]  ref_pin,
  input  logic [5:0]  ref_wpin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [29:0] res_map,
  output logic [3:0]  res_count,
  output logic        res_err
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        res_valid_q;
  logic [1:0]  sel_q;
  logic [15:0] func_q;
  logic [3:0]  pin_q;
  logic [29:0] map_q;
  logic [3:0]  count_q;
  logic        err_q;

  logic [2:0] ones;
  logic [2:0] idx;
  logic [2:0] code;
  logic [4:0] slot_base;

  function automatic logic [3:0] pin_count(input logic [1:0] sel);
    case (sel)
      2'b00:   pin_count = 4'd4;
      2'b01:   pin_count = 4'd6;
      2'b10:   pin_count = 4'd10;
      default: pin_count = 4'd6;
    endcase
  endfunction

  // Codes 6 and 7 flag a malformed decoder output; 0..5 is the one-hot bit index.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 6; i++) begin
      if (ref_wpin[i]) begin
        ones = ones + 3'd1;
        idx  = 3'(i);
      end
    end
    if (ones == 3'd0) begin
      code = 3'b111;
    end else if (ones == 3'd1) begin
      code = idx;
    end else begin
      code = 3'b110;
    end
    slot_base = 5'(pin_q) * 5'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      sel_q       <= '0;
      func_q      <= '0;
      pin_q       <= '0;
      map_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            sel_q       <= req_sel;
            func_q      <= req_func;
            map_q       <= '0;
            err_q       <= 1'b0;
            pin_q       <= '0;
            count_q     <= pin_count(req_sel);
            req_ready_q <= 1'b0;
            state_q     <= StScan;
          end
        end
        StScan: begin
          map_q[slot_base +: 3] <= code;
          if (code[2:1] == 2'b11) begin
            err_q <= 1'b1;
          end
          // pin_q returns to 0 on the last pin so ref_pin reads 0 outside the sweep.
          if (pin_q == count_q - 4'd1) begin
            pin_q       <= '0;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            pin_q <= pin_q + 4'd1;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign ref_sel   = sel_q;
  assign ref_func  = func_q;
  assign ref_pin   = pin_q;
  assign res_map   = map_q;
  assign res_count = count_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_ucomb_scan.sv
// Scoreboard bench for ucomb_scan: stimulus pushes expected results, a monitor pops them
// on each accepted result; a decoder stub drives ref_wpin according to the active test mode.
module tb_ucomb_scan;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic [15:0] req_func;
  logic [1:0]  ref_sel;
  logic [15:0] ref_func;
  logic [3:0]  ref_pin;
  logic [5:0]  ref_wpin;
  logic        res_valid;
  logic        res_ready;
  logic [29:0] res_map;
  logic [3:0]  res_count;
  logic        res_err;

  typedef struct packed {
    logic [29:0] map;
    logic [3:0]  count;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   mode;

  ucomb_scan dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_func  (req_func),
    .ref_sel   (ref_sel),
    .ref_func  (ref_func),
    .ref_pin   (ref_pin),
    .ref_wpin  (ref_wpin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_map   (res_map),
    .res_count (res_count),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder stub.
  always_comb begin
    ref_wpin = 6'b000000;
    case (mode)
      0: ref_wpin = 6'b000001 << ((32'(ref_pin) + 1) % 6);
      1: ref_wpin = 6'b000001;
      2: begin
        if (ref_pin == 4'd2) ref_wpin = 6'b000000;
        else if (ref_pin == 4'd4) ref_wpin = 6'b100100;
        else ref_wpin = 6'b000010;
      end
      default: ref_wpin = 6'b000010;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change on negedge, so #2 later shows the values the next edge samples.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_map", 32'(res_map), 32'(e.map));
          chk("res_count", 32'(res_count), 32'(e.count));
          chk("res_err", 32'(res_err), 32'(e.err));
        end
      end
    end
  end

  // Accept at the next edge, then check the sweep and res_valid timing.
  task automatic run_req(input logic [1:0] sel, input logic [15:0] func, input int n,
                         input string tag);
    req_valid = 1'b1;
    req_sel   = sel;
    req_func  = func;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = 2'b00;
    req_func  = 16'h0000;
    chk({tag, "_ref_sel"}, 32'(ref_sel), 32'(sel));
    chk({tag, "_ref_func"}, 32'(ref_func), 32'(func));
    for (int k = 0; k < n; k++) begin
      chk({tag, "_ref_pin"}, 32'(ref_pin), 32'(k));
      if (res_valid) chk({tag, "_early_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_valid_rise"}, 32'(res_valid), 32'd1);
    chk({tag, "_pin_done"}, 32'(ref_pin), 32'd0);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_ref_pin"}, 32'(ref_pin), 32'd0);
    chk({tag, "_ref_sel"}, 32'(ref_sel), 32'd0);
    chk({tag, "_ref_func"}, 32'(ref_func), 32'd0);
    chk({tag, "_res_map"}, 32'(res_map), 32'd0);
    chk({tag, "_res_count"}, 32'(res_count), 32'd0);
    chk({tag, "_res_err"}, 32'(res_err), 32'd0);
  endtask

  initial begin
    int guard;
    checks    = 0;
    errors    = 0;
    mode      = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = 2'b00;
    req_func  = 16'h0000;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_chk("rst");

    // sel 00: codes 1,2,3,4 on pins 0..3.
    mode = 0;
    exp_q.push_back('{map: 30'h8D1, count: 4'd4, err: 1'b0});
    run_req(2'b00, 16'h0006, 4, "a");
    @(negedge clk);
    chk("a_idle_ready", 32'(req_ready), 32'd1);
    chk("a_idle_valid", 32'(res_valid), 32'd0);

    // sel 10: every pin decodes to bit 0.
    mode = 1;
    exp_q.push_back('{map: 30'h0, count: 4'd10, err: 1'b0});
    run_req(2'b10, 16'hBEEF, 10, "b");
    @(negedge clk);

    // sel 01: missing wire on pin 2, double wire on pin 4.
    mode = 2;
    exp_q.push_back('{map: 30'h0E3C9, count: 4'd6, err: 1'b1});
    run_req(2'b01, 16'h00F0, 6, "c");
    @(negedge clk);

    // Backpressure, ignored req_valid pulses, and err cleared by the new capture.
    mode = 3;
    res_ready = 1'b0;
    exp_q.push_back('{map: 30'h9249, count: 4'd6, err: 1'b0});
    req_valid = 1'b1;
    req_sel   = 2'b01;
    req_func  = 16'h1234;
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 2'b10;
    req_func  = 16'hFFFF;
    chk("d_scan_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("d_valid", 32'(res_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      req_valid = (k == 2);
      chk("d_hold_map", 32'(res_map), 32'h9249);
      chk("d_hold_valid", 32'(res_valid), 32'd1);
      chk("d_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("d_ref_sel", 32'(ref_sel), 32'd1);
    chk("d_ref_func", 32'(ref_func), 32'h1234);
    chk("d_count", 32'(res_count), 32'd6);
    res_ready = 1'b1;
    @(negedge clk);
    chk("d_idle_ready", 32'(req_ready), 32'd1);
    chk("d_idle_valid", 32'(res_valid), 32'd0);

    // Reset mid-SCAN on sel 11; no result must appear.
    req_valid = 1'b1;
    req_sel   = 2'b11;
    req_func  = 16'hA5A5;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (ref_pin != 4'd3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("e_reach_pin3", 32'(ref_pin), 32'd3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_chk("e_rst");
    repeat (8) begin
      if (res_valid) chk("e_no_result", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    mode = 0;
    exp_q.push_back('{map: 30'h8D1, count: 4'd4, err: 1'b0});
    run_req(2'b00, 16'h0006, 4, "f");
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ucomb_scan.md
# ucomb_scan

Sequential pin-sweep controller that sits directly upstream of the universal-gate wiring decoder. It accepts one gate request (selector plus function word) per handshake. It then steps the decoder's pin input through every pin position that the selected gate type uses, one pin per cycle. It samples the decoder's one-hot wiring output each cycle and packs the results into a per-pin wiring map, which it returns over a valid/ready result handshake.

## Interface

Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request (IDLE only)
- req_sel  in  2  gate type: 00 = 2-in/1-out, 01 = 3-in/1-out, 10 = 4-in/1-out, 11 = 2x 2-in
- req_func  in  16  gate function word
- ref_sel  out  2  captured selector, driven to the wiring decoder
- ref_func  out  16  captured function word, driven to the wiring decoder
- ref_pin  out  4  pin index currently being probed
- ref_wpin  in  6  one-hot wiring from the decoder; combinational from ref_* in the same cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_map  out  30  3-bit code per pin, pin k at bits [3k+2:3k]
- res_count  out  4  number of pins swept (N)
- res_err  out  1  at least one swept pin had a non-one-hot ref_wpin

## Operation

- Pin count N is derived from the captured selector:
  - sel 00 → N = 4
  - sel 01 → N = 6
  - sel 10 → N = 10
  - sel 11 → N = 6
- FSM has three states: IDLE, SCAN, DONE.
- **IDLE:**
  - req_ready = 1.
  - On req_valid, capture req_sel and req_func into ref_sel and ref_func.
  - Clear res_map to 0 and res_err to 0, set pin counter to 0, load res_count = N, go to SCAN.
- **SCAN:**
  - ref_pin = pin counter.
  - Each cycle, encode ref_wpin into a code and write it into slot ref_pin of res_map.
  - If pin counter == N−1, go to DONE; otherwise increment the counter.
- **Code encoding** (from ref_wpin):
  - Exactly one bit i set → code = i (0..5).
  - All zero → code = 3'b111, and set res_err.
  - More than one bit set → code = 3'b110, and set res_err.
- **DONE:**
  - res_valid = 1.
  - res_map, res_count and res_err are held stable.
  - On res_ready, go to IDLE.
- Slots at positions ≥ N remain 3'b000.
- ref_sel and ref_func hold their captured values in every state until the next capture.
- ref_pin = 0 in IDLE and DONE.
- req_valid is ignored outside IDLE. req_ready = 0 in SCAN and DONE.
- res_err is sticky within a request and cleared only at the next capture.

## Timing

- Reset values:
  - State IDLE.
  - req_ready = 1, res_valid = 0.
  - ref_sel = 0, ref_func = 0, ref_pin = 0.
  - res_map = 0, res_count = 0, res_err = 0.
- Request accepted at edge E0. SCAN occupies the N cycles after E0; ref_pin takes values 0..N−1 in consecutive cycles.
- res_valid rises in cycle N+1 after E0 (registered) and stays high until the edge where res_ready = 1. The FSM is in IDLE on the following cycle.
- Minimum request spacing is N+2 cycles. No request/result overlap.
- res_valid and res_ready high in the same cycle as entry to DONE complete the transfer at the next edge.
- rst asserted in any state, including mid-SCAN, forces the reset values at that edge. The partial map is discarded and no result is emitted.
- ref_wpin is sampled only on SCAN-cycle edges; its value in IDLE and DONE has no effect.
- Counter wraps never occur: the counter never exceeds 9.

## Test plan

- **Reset:** assert rst for 2 cycles mid-operation → req_ready = 1, res_valid = 0, ref_pin = 0, res_map = 0, res_err = 0 on the first cycle after rst is released.
- **sel 00, func 0x0006; stub returns ref_wpin = one-hot((pin+1) mod 6):**
  - ref_pin sequence 0,1,2,3 over 4 cycles.
  - res_valid rises 5 cycles after accept.
  - res_map[11:0] = {3'd4, 3'd3, 3'd2, 3'd1}, upper bits 0.
  - res_count = 4, res_err = 0.
- **sel 10; stub always returns 6'b000001:**
  - ref_pin sweeps 0..9.
  - res_map = 0, res_count = 10, res_err = 0.
  - res_valid rises 11 cycles after accept.
- **sel 01; stub returns 0 at pin 2 and 6'b100100 at pin 4, otherwise 6'b000010:**
  - slot 2 = 3'b111, slot 4 = 3'b110, other slots 0..5 = 1.
  - res_err = 1.
- **Backpressure:**
  - Hold res_ready = 0 for 5 cycles after res_valid → res_map stable, req_ready = 0, and a req_valid pulse during SCAN/DONE is ignored.
  - Raise res_ready → IDLE next cycle.
  - A new request then clears res_err.
- **Reset mid-SCAN:** assert rst when ref_pin = 3 on sel 11 → no res_valid is produced. A following request with sel 00 sweeps only 4 pins and returns res_count = 4.
